// File: rtl/aes_masked_pkg.sv
// +------------------------------------------------------------------+
// | aes_masked_pkg                                                   |
// | Shared types and helpers for the masked AES S-box datapath.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package aes_masked_pkg;

   localparam logic [15:0] LFSR_TAPS_C    = 16'hB400;
   localparam logic [15:0] SEED_DEFAULT_C = 16'hACE1;

   typedef struct packed {
      logic [7:0] s0;
      logic [7:0] s1;
   } share_pair_t;

   // Eight Galois steps: shift right, fold the taps in when a one falls out.
   function automatic logic [15:0] lfsr_step8(input logic [15:0] s,
                                              input logic [15:0] taps = LFSR_TAPS_C);
      logic [15:0] r;
      r = s;
      for (int i = 0; i < 8; i++) begin
         if (r[0]) r = (r >> 1) ^ taps;
         else      r = r >> 1;
      end
      return r;
   endfunction

   // Per 2-bit group k: {hi^lo, hi, lo}, the masked GF(2^2) multiplier operand layout.
   function automatic logic [11:0] to_factors(input logic [7:0] b);
      logic [11:0] f;
      f = '0;
      for (int k = 0; k < 4; k++) begin
         f[3*k +: 3] = {b[2*k+1] ^ b[2*k], b[2*k+1], b[2*k]};
      end
      return f;
   endfunction

endpackage

`default_nettype wire

// File: rtl/share_skid_buf.sv
// +------------------------------------------------------------------+
// | share_skid_buf                                                   |
// | Two-entry valid/ready skid buffer carrying a share pair.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module share_skid_buf
   import aes_masked_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  share_pair_t in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output share_pair_t out_data
);

   logic        r_out_valid;
   share_pair_t r_out_data;
   logic        r_skid_valid;
   share_pair_t r_skid_data;
   logic        r_in_ready;

   logic        w_accept;
   logic        w_emit;
   logic        w_out_valid;
   share_pair_t w_out_data;
   logic        w_skid_valid;
   share_pair_t w_skid_data;

   assign w_accept = in_valid & r_in_ready;
   assign w_emit   = r_out_valid & out_ready;

   // The skid entry only fills when the output register is occupied and not draining.
   always_comb begin
      w_out_valid  = r_out_valid;
      w_out_data   = r_out_data;
      w_skid_valid = r_skid_valid;
      w_skid_data  = r_skid_data;
      if (r_skid_valid) begin
         if (w_emit) begin
            w_out_data   = r_skid_data;
            w_skid_valid = 1'b0;
         end
      end else if (w_accept) begin
         if (r_out_valid && !w_emit) begin
            w_skid_data  = in_data;
            w_skid_valid = 1'b1;
         end else begin
            w_out_data  = in_data;
            w_out_valid = 1'b1;
         end
      end else if (w_emit) begin
         w_out_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_in_ready   <= 1'b1;
      end else begin
         r_out_valid  <= w_out_valid;
         r_out_data   <= w_out_data;
         r_skid_valid <= w_skid_valid;
         r_skid_data  <= w_skid_data;
         r_in_ready   <= !w_skid_valid;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: rtl/masked_share_encoder.sv
// +------------------------------------------------------------------+
// | masked_share_encoder                                             |
// | Splits plain bytes into two Boolean shares with an LFSR mask.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module masked_share_encoder
   import aes_masked_pkg::*;
#(
   parameter logic [15:0] SEED_DEFAULT = SEED_DEFAULT_C,
   parameter logic [15:0] LFSR_TAPS    = LFSR_TAPS_C
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        seed_load,
   input  logic [15:0] seed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_s0,
   output logic [7:0]  out_s1,
   output logic [11:0] out_f0,
   output logic [11:0] out_f1,
   output logic [15:0] out_count
);

   localparam logic [15:0] c_seed_init = (SEED_DEFAULT == 16'h0000) ? 16'h0001 : SEED_DEFAULT;

   logic [15:0] r_lfsr;
   logic [15:0] r_count;

   logic        w_in_ready;
   logic        w_out_valid;
   logic        w_accept;
   logic        w_emit;
   share_pair_t w_in_pair;
   share_pair_t w_out_pair;

   assign w_accept     = in_valid & w_in_ready;
   assign w_emit       = w_out_valid & out_ready;
   assign w_in_pair.s0 = in_data ^ r_lfsr[7:0];
   assign w_in_pair.s1 = r_lfsr[7:0];

   // A seed load wins over the advance; the byte accepted alongside it already took the old mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= c_seed_init;
      end else if (seed_load) begin
         r_lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
      end else if (w_accept) begin
         r_lfsr <= lfsr_step8(r_lfsr, LFSR_TAPS);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         r_count <= '0;
      else if (w_emit) r_count <= r_count + 16'd1;
   end

   share_skid_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (w_in_ready),
      .in_data   (w_in_pair),
      .out_valid (w_out_valid),
      .out_ready (out_ready),
      .out_data  (w_out_pair)
   );

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_s0    = w_out_pair.s0;
   assign out_s1    = w_out_pair.s1;
   assign out_f0    = to_factors(w_out_pair.s0);
   assign out_f1    = to_factors(w_out_pair.s1);
   assign out_count = r_count;

endmodule

`default_nettype wire
